// File: rtl/datapath_pkg.sv
// Purpose: shared widths and bus-source encoding for the register-transfer datapath slice.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: none; the controller sequences every transfer explicitly.
package datapath_pkg;

  localparam int DATA_W = 32;
  localparam int IN_W   = 8;

  // Which source currently owns the shared bus.
  typedef enum logic [1:0] {
    SRC_A  = 2'd0,
    SRC_RB = 2'd1,
    SRC_RA = 2'd2,
    SRC_RZ = 2'd3
  } bus_src_t;

  // Fixed priority RZ > RA > RB > A. Several selects at once are legal;
  // the highest one simply wins, so the bus is never left undriven.
  function automatic bus_src_t pick_src(input logic rz_out,
                                        input logic ra_out,
                                        input logic rb_out);
    if (rz_out)      return SRC_RZ;
    else if (ra_out) return SRC_RA;
    else if (rb_out) return SRC_RB;
    else             return SRC_A;
  endfunction

endpackage

// File: rtl/reg32.sv
// Purpose: width-parameterised load-enable register with asynchronous clear.
// Latency: d is captured on the rising edge where en=1; q follows immediately after.
// Backpressure: none; holds its value while en=0.
//
// Ports: clk (rising edge), rst (async, active-high, zeroes q),
//        en (load enable), d (next value), q (stored value).
module reg32 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/data_path.sv
// Purpose: three registers (RA, RB, RZ) on one shared bus, plus the adders feeding RA and RZ.
// Latency: loads land one rising edge after the enable; the bus itself is combinational.
// Backpressure: none; all sequencing comes from the external control-step logic.
//
// Ports:
//   clock               rising-edge clock for all registers
//   clear               asynchronous active-high reset of RA/RB/RZ
//   A                   external data, zero-extended onto the bus when no register drives it
//   RegisterAImmediate  unsigned immediate added to the bus on every RA load
//   RZout/RAout/RBout   bus drive selects (priority RZ > RA > RB > A)
//   RAin/RBin/RZin      register load enables
//   BusMuxOut           current bus value
module data_path #(
  parameter int DATA_W = 32,
  parameter int IN_W   = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [IN_W-1:0]   A,
  input  logic [IN_W-1:0]   RegisterAImmediate,
  input  logic              RZout,
  input  logic              RAout,
  input  logic              RBout,
  input  logic              RAin,
  input  logic              RBin,
  input  logic              RZin,
  output logic [DATA_W-1:0] BusMuxOut
);

  import datapath_pkg::*;

  logic [DATA_W-1:0] ra_q;
  logic [DATA_W-1:0] rb_q;
  logic [DATA_W-1:0] rz_q;
  logic [DATA_W-1:0] a_ext;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] ra_d;
  logic [DATA_W-1:0] rz_d;
  bus_src_t          bus_src;

  assign a_ext   = {{(DATA_W-IN_W){1'b0}}, A};
  assign imm_ext = {{(DATA_W-IN_W){1'b0}}, RegisterAImmediate};

  // Bus mux. The default arm always yields zext(A), so no X ever escapes.
  always_comb begin
    bus_src   = pick_src(RZout, RAout, RBout);
    BusMuxOut = a_ext;
    case (bus_src)
      SRC_RZ:  BusMuxOut = rz_q;
      SRC_RA:  BusMuxOut = ra_q;
      SRC_RB:  BusMuxOut = rb_q;
      default: BusMuxOut = a_ext;
    endcase
  end

  // Both sums use pre-edge values, so RA <= RA + imm (RAout with RAin)
  // and simultaneous RA/RZ loads behave as a clean read-modify-write.
  // Carry out is discarded: results wrap modulo 2^DATA_W.
  assign ra_d = BusMuxOut + imm_ext;
  assign rz_d = ra_q + rb_q;

  reg32 #(.W(DATA_W)) u_ra (
    .clk (clock),
    .rst (clear),
    .en  (RAin),
    .d   (ra_d),
    .q   (ra_q)
  );

  reg32 #(.W(DATA_W)) u_rb (
    .clk (clock),
    .rst (clear),
    .en  (RBin),
    .d   (BusMuxOut),
    .q   (rb_q)
  );

  reg32 #(.W(DATA_W)) u_rz (
    .clk (clock),
    .rst (clear),
    .en  (RZin),
    .d   (rz_d),
    .q   (rz_q)
  );

endmodule

// File: tb/tb_data_path.sv
// Purpose: directed self-checking bench for data_path; registers are observed through the bus.
// Latency: inputs change 1ns after a rising edge, checks happen 1ns after inputs settle.
// Backpressure: n/a.
module tb_data_path;

  logic        clock;
  logic        clear;
  logic [7:0]  A;
  logic [7:0]  RegisterAImmediate;
  logic        RZout, RAout, RBout;
  logic        RAin, RBin, RZin;
  logic [31:0] BusMuxOut;

  int checks   = 0;
  int failures = 0;

  data_path dut (
    .clock              (clock),
    .clear              (clear),
    .A                  (A),
    .RegisterAImmediate (RegisterAImmediate),
    .RZout              (RZout),
    .RAout              (RAout),
    .RBout              (RBout),
    .RAin               (RAin),
    .RBin               (RBin),
    .RZin               (RZin),
    .BusMuxOut          (BusMuxOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    RZout = 1'b0; RAout = 1'b0; RBout = 1'b0;
    RAin  = 1'b0; RBin  = 1'b0; RZin  = 1'b0;
    RegisterAImmediate = 8'h00;
  endtask

  // One rising edge, then step 1ns clear of it and drop all controls.
  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  // Put one register on the bus (0=RA,1=RB,2=RZ) and compare.
  task automatic peek(input int which, input string tag, input logic [31:0] exp);
    idle();
    case (which)
      0:       RAout = 1'b1;
      1:       RBout = 1'b1;
      default: RZout = 1'b1;
    endcase
    #1;
    chk(tag, BusMuxOut, exp);
    idle();
  endtask

  initial begin
    idle();
    A     = 8'h05;
    clear = 1'b1;
    #2;

    // Reset state.
    chk("rst_bus_zext_a", BusMuxOut, 32'h0000_0005);
    peek(0, "rst_ra", 32'h0);
    peek(1, "rst_rb", 32'h0);
    peek(2, "rst_rz", 32'h0);
    RAin = 1'b1;
    tick();
    peek(0, "rst_ignores_load", 32'h0);

    // Release clear between edges.
    clear = 1'b0;
    A     = 8'h00;
    #1;
    chk("post_rst_bus", BusMuxOut, 32'h0);

    // A -> RA -> RB.
    A = 8'h05; RAin = 1'b1;
    tick();
    peek(0, "a_to_ra", 32'h05);
    A = 8'h00; RAout = 1'b1; RBin = 1'b1;
    tick();
    peek(1, "ra_to_rb", 32'h05);

    // Hold: no enable, RA/RB unchanged.
    A = 8'hEE;
    tick();
    peek(0, "ra_hold", 32'h05);
    peek(1, "rb_hold", 32'h05);

    // Immediate added on RA load.
    A = 8'h10; RegisterAImmediate = 8'h03; RAin = 1'b1;
    tick();
    peek(0, "ra_imm", 32'h13);

    // Build RA = 0xFFFFFFFF: RA=1, then 31 rounds of RA <= 2*RA + 1.
    A = 8'h01; RAin = 1'b1;
    tick();
    for (int i = 0; i < 31; i++) begin
      RAout = 1'b1; RBin = 1'b1;
      tick();
      RZin = 1'b1;
      tick();
      RZout = 1'b1; RAin = 1'b1; RegisterAImmediate = 8'h01;
      tick();
    end
    peek(0, "ra_all_ones", 32'hFFFF_FFFF);
    RAout = 1'b1; RAin = 1'b1; RegisterAImmediate = 8'h02;
    tick();
    peek(0, "ra_wrap", 32'h0000_0001);

    // Adder into RZ.
    A = 8'h07; RAin = 1'b1;
    tick();
    A = 8'h09; RBin = 1'b1;
    tick();
    RZin = 1'b1;
    tick();
    peek(2, "rz_sum", 32'h10);

    // Simultaneous RA and RZ loads: RZ must use the old RA (7+9).
    A = 8'h20; RAin = 1'b1; RZin = 1'b1;
    tick();
    peek(0, "simul_ra", 32'h20);
    peek(2, "simul_rz_old_ra", 32'h10);

    // Priority: RA=1, RB=2, RZ=3.
    A = 8'h01; RAin = 1'b1;
    tick();
    A = 8'h02; RBin = 1'b1;
    tick();
    RZin = 1'b1;
    tick();
    A = 8'hAA;
    RZout = 1'b1; RAout = 1'b1; RBout = 1'b1;
    #1; chk("prio_rz", BusMuxOut, 32'h3);
    RZout = 1'b0;
    #1; chk("prio_ra", BusMuxOut, 32'h1);
    RAout = 1'b0;
    #1; chk("prio_rb", BusMuxOut, 32'h2);
    RBout = 1'b0;
    #1; chk("prio_a", BusMuxOut, 32'hAA);

    // Mid-operation clear.
    A = 8'h55; RAin = 1'b1;
    tick();
    peek(0, "ra_55", 32'h55);
    clear = 1'b1;
    #1;
    peek(0, "mid_clear_ra", 32'h0);
    peek(1, "mid_clear_rb", 32'h0);
    clear = 1'b0;
    A = 8'h01; RAin = 1'b1;
    tick();
    peek(0, "post_clear_load", 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- Minimal bus-based datapath: three 32-bit registers (RA, RB, RZ) on a shared 32-bit bus, plus an adder feeding RZ.
- The bus is driven by a priority multiplexer selecting RZ, RA, RB or the external 8-bit input A.
- Serves as the first integration slice of the CPU datapath, for register-transfer sequencing under a control-step state machine.

Parameters:
- DATA_W, 32, bus and register width.
- IN_W, 8, width of external input A and of the immediate RegisterAImmediate.

Ports:
- clock  input  1  system clock; all registers are rising-edge triggered.
- clear  input  1  asynchronous, active-high reset.
- A  input  IN_W  external data; zero-extended onto the bus when no register drives it.
- RegisterAImmediate  input  IN_W  unsigned immediate added to the bus value on every RA load.
- RZout  input  1  drive RZ onto the bus.
- RAout  input  1  drive RA onto the bus.
- RBout  input  1  drive RB onto the bus.
- RAin  input  1  load enable for RA.
- RBin  input  1  load enable for RB.
- RZin  input  1  load enable for RZ.
- BusMuxOut  output  DATA_W  current bus value (combinational).

Behaviour:
- Reset: clear=1 asynchronously forces RA=RB=RZ=0, regardless of clock or enables. With clear=1 and no out-select asserted, BusMuxOut = zext(A). After reset with A=0, BusMuxOut=0.
- Bus mux is purely combinational with fixed priority: RZout > RAout > RBout > default zext(A) ({24'b0,A}).
  - Multiple out-selects asserted: the highest-priority one wins. This is not an error.
- RA: on rising edge with RAin=1, RA <= BusMuxOut + zext(RegisterAImmediate), mod 2^32 (wraps, no carry out).
- RB: on rising edge with RBin=1, RB <= BusMuxOut.
- RZ: on rising edge with RZin=1, RZ <= RA + RB, mod 2^32, using pre-edge register values.
- Enables deasserted: the register holds its value.
- Latency:
  - Load takes effect one rising edge after the enable is sampled high.
  - Loaded value appears on BusMuxOut in the same cycle its out-select is asserted.
- Simultaneous loads: all enabled registers update on the same edge from pre-edge bus/register values.
  - A register that both drives the bus and is loaded (e.g. RAout=1, RAin=1) uses its old value. This is valid read-modify-write, e.g. RA <= RA + imm.
- clear asserted mid-sequence: registers zero immediately. Load enables sampled while clear=1 are ignored. Normal loads resume on the first rising edge after clear deasserts.
- No internal state machine; sequencing is the controller's responsibility.
- No X propagation from undriven bus: the default path always selects zext(A).

Decomposition:
- Shared package (datapath_pkg):
  - DATA_W / IN_W constants.
  - Bus source select encoding: SRC_A, SRC_RB, SRC_RA, SRC_RZ.
- One natural sub-module: reg32 (width-parameterized, enable-load register with async active-high clear). Instantiated three times.
- Bus mux and adders stay inline in data_path.

Test Plan:
- Reset: clear=1, A=8'h05, all selects 0 -> RA=RB=RZ=0; BusMuxOut=32'h00000005; a clock edge with RAin=1 still leaves RA=0.
- Transfer A->RA->RB:
  - A=8'h05, imm=0, RAin=1 for one edge -> RA=32'h05.
  - Then RAout=1, RBin=1 for one edge -> RB=32'h05.
  - Then RBout=1 -> BusMuxOut=32'h05.
- Immediate on load: A=8'h10, RegisterAImmediate=8'h03, RAin=1 -> RA=32'h13. Wrap check: RA=32'hFFFFFFFF, RAout=1, RAin=1, imm=8'h02 -> RA=32'h00000001.
- Adder/RZ: RA=32'h07, RB=32'h09, RZin=1 -> RZ=32'h10. Then RZout=1 -> BusMuxOut=32'h10.
- Bus priority: RA=1, RB=2, RZ=3.
  - RZout=RAout=RBout=1 -> bus=3.
  - Drop RZout -> bus=1.
  - Drop RAout -> bus=2.
  - All 0 with A=8'hAA -> bus=32'hAA.
- Mid-operation reset: RA=32'h55 loaded, assert clear between edges -> RA reads 0 before the next edge. Next edge with RAin=1, clear=0, A=8'h01 -> RA=1.
